// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction/data memory arbiter: state encoding
// and the default starvation limit.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } arbState_t;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive data grants made while a fetch was waiting;
// sat tells the arbiter that the fetch side must win the next contention.
module arb_starve_cnt
    import cpu_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clock,
    input  logic start,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starveCnt;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge start) begin
        if (!start) begin
            starveCnt <= '0;
        end else if (clr) begin
            starveCnt <= '0;
        end else if (inc) begin
            starveCnt <= satInc(starveCnt);
        end
    end

    assign sat = (starveCnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between an instruction fetch port and a
// data load/store port, with bounded starvation of the fetch side.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clock,
    input  logic              start,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    arbState_t         state;
    arbState_t         stateNext;
    logic              grantI;
    logic              grantD;
    logic              starveSat;
    logic [ADDR_W-1:0] addrQ;
    logic              weQ;
    logic [31:0]       wdataQ;
    logic [31:0]       iRdataQ;
    logic [31:0]       dRdataQ;

    always_comb begin
        stateNext = state;
        grantI    = 1'b0;
        grantD    = 1'b0;
        case (state)
            IDLE: begin
                // Data wins contention until the fetch side has waited STARVE_MAX grants
                if (d_req && (!i_req || !starveSat)) begin
                    grantD    = 1'b1;
                    stateNext = BUSY_D;
                end else if (i_req) begin
                    grantI    = 1'b1;
                    stateNext = BUSY_I;
                end
            end
            BUSY_I:  if (mem_ready) stateNext = RESP_I;
            BUSY_D:  if (mem_ready) stateNext = RESP_D;
            RESP_I:  stateNext = IDLE;
            RESP_D:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge start) begin
        if (!start) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clock or negedge start) begin
        if (!start) begin
            addrQ  <= '0;
            weQ    <= 1'b0;
            wdataQ <= '0;
        end else if (grantD) begin
            addrQ  <= d_addr;
            weQ    <= d_we;
            wdataQ <= d_wdata;
        end else if (grantI) begin
            addrQ  <= i_addr;
            weQ    <= 1'b0;
            wdataQ <= '0;
        end
    end

    always_ff @(posedge clock or negedge start) begin
        if (!start) begin
            iRdataQ <= '0;
            dRdataQ <= '0;
        end else begin
            if (state == BUSY_I && mem_ready) iRdataQ <= mem_rdata;
            if (state == BUSY_D && mem_ready && !weQ) dRdataQ <= mem_rdata;
        end
    end

    arb_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) uStarve (
        .clock(clock),
        .start(start),
        .inc  (grantD && i_req),
        .clr  (grantI || (grantD && !i_req)),
        .sat  (starveSat)
    );

    // Handshake outputs come from the state register alone
    assign busy      = (state != IDLE);
    assign mem_req   = (state == BUSY_I) || (state == BUSY_D);
    assign mem_we    = (state == BUSY_D) && weQ;
    assign mem_addr  = mem_req ? addrQ : '0;
    assign mem_wdata = (state == BUSY_D) ? wdataQ : '0;
    assign i_ready   = (state == RESP_I);
    assign d_ready   = (state == RESP_D);
    assign i_rdata   = iRdataQ;
    assign d_rdata   = dRdataQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clock = 1'b0;
    logic              start = 1'b0;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_ready;
    logic [31:0]       i_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [31:0]       d_wdata = '0;
    logic              d_ready;
    logic [31:0]       d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic              busy;

    always #5 clock = ~clock;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clock    (clock),
        .start    (start),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ready  (i_ready),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, followed by a one-cycle response
    bit                mTx = 1'b0;
    bit                mTxData = 1'b0;
    bit                mTxWe = 1'b0;
    bit                mResp = 1'b0;
    bit                mRespData = 1'b0;
    logic [ADDR_W-1:0] mTxAddr = '0;
    logic [31:0]       mTxWdata = '0;
    logic [31:0]       mI = '0;
    logic [31:0]       mD = '0;
    int                mStarve = 0;

    always @(posedge clock or negedge start) begin
        if (!start) begin
            mTx = 1'b0; mResp = 1'b0; mTxData = 1'b0; mTxWe = 1'b0;
            mTxAddr = '0; mTxWdata = '0; mI = '0; mD = '0; mStarve = 0;
        end else if (mResp) begin
            mResp = 1'b0;
        end else if (mTx) begin
            if (mem_ready) begin
                if (!mTxData) mI = mem_rdata;
                else if (!mTxWe) mD = mem_rdata;
                mTx = 1'b0;
                mResp = 1'b1;
                mRespData = mTxData;
            end
        end else if (d_req && (!i_req || mStarve < STARVE_MAX)) begin
            mTx = 1'b1; mTxData = 1'b1; mTxAddr = d_addr; mTxWe = d_we; mTxWdata = d_wdata;
            mStarve = i_req ? ((mStarve < STARVE_MAX) ? mStarve + 1 : STARVE_MAX) : 0;
        end else if (i_req) begin
            mTx = 1'b1; mTxData = 1'b0; mTxAddr = i_addr; mTxWe = 1'b0; mTxWdata = '0;
            mStarve = 0;
        end
    end

    always @(negedge clock) begin
        check("busy",      64'(busy),      64'(mTx || mResp));
        check("mem_req",   64'(mem_req),   64'(mTx));
        check("mem_we",    64'(mem_we),    64'(mTx && mTxData && mTxWe));
        check("mem_addr",  64'(mem_addr),  64'(mTx ? mTxAddr : '0));
        check("mem_wdata", 64'(mem_wdata), 64'((mTx && mTxData) ? mTxWdata : 32'h0));
        check("i_ready",   64'(i_ready),   64'(mResp && !mRespData));
        check("d_ready",   64'(d_ready),   64'(mResp && mRespData));
        check("i_rdata",   64'(i_rdata),   64'(mI));
        check("d_rdata",   64'(d_rdata),   64'(mD));
    end

    // Memory side: 0 = manual values, 1 = responds after memLat cycles of mem_req, 2 = random
    int          memMode = 0;
    int          memLat = 1;
    int          memCnt = 0;
    logic [31:0] memVal = '0;
    logic        manReady = 1'b0;
    logic [31:0] manRdata = '0;

    always @(negedge clock) begin
        case (memMode)
            1: begin
                if (mem_req) begin
                    memCnt++;
                    mem_ready = (memCnt >= memLat);
                end else begin
                    memCnt = 0;
                    mem_ready = 1'b0;
                end
                mem_rdata = memVal;
            end
            2: begin
                mem_ready = ($urandom_range(0, 2) == 0);
                mem_rdata = $urandom;
            end
            default: begin
                mem_ready = manReady;
                mem_rdata = manRdata;
            end
        endcase
    end

    string grantStr = "";
    logic  prevMemReq = 1'b0;

    always @(negedge clock) begin
        if (mem_req && !prevMemReq && grantStr.len() < 64)
            grantStr = {grantStr, (mem_addr == 32'h40) ? "I" : "D"};
        prevMemReq = mem_req;
    end

    initial begin
        int  cnt1;
        int  cnt2;
        bit  seen;

        repeat (2) @(negedge clock);
        check("rst_busy",    64'(busy),    64'h0);
        check("rst_mem_req", 64'(mem_req), 64'h0);
        check("rst_i_rdata", 64'(i_rdata), 64'h0);
        check("rst_d_rdata", 64'(d_rdata), 64'h0);
        start = 1'b1;

        // Fetch with one-cycle memory
        memMode = 1; memLat = 1; memVal = 32'h8C010004;
        @(negedge clock); i_req = 1'b1; i_addr = 32'h40;
        @(negedge clock);
        check("fetch_mem_req",  64'(mem_req),  64'h1);
        check("fetch_mem_addr", 64'(mem_addr), 64'h40);
        check("fetch_mem_we",   64'(mem_we),   64'h0);
        i_req = 1'b0;
        @(negedge clock);
        check("fetch_i_ready", 64'(i_ready), 64'h1);
        check("fetch_i_rdata", 64'(i_rdata), 64'h8C010004);
        @(negedge clock);
        check("fetch_i_ready_once", 64'(i_ready), 64'h0);
        check("fetch_idle",         64'(busy),    64'h0);

        // Store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        @(negedge clock);
        check("store_mem_we",    64'(mem_we),    64'h1);
        check("store_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        check("store_mem_addr",  64'(mem_addr),  64'h100);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clock);
        check("store_d_ready", 64'(d_ready), 64'h1);
        check("store_d_rdata", 64'(d_rdata), 64'h0);
        @(negedge clock);
        check("store_d_ready_once", 64'(d_ready), 64'h0);

        // Load with five wait cycles, request withdrawn mid-access
        memLat = 5; memVal = 32'hCAFEF00D;
        d_req = 1'b1; d_addr = 32'h200;
        cnt1 = 0; cnt2 = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            if (k == 0) d_req = 1'b0;
            if (mem_req) cnt1++;
            if (d_ready) cnt2++;
        end
        check("wait_mem_req_cycles", 64'(cnt1), 64'd5);
        check("wait_d_ready_pulses", 64'(cnt2), 64'd1);
        check("wait_d_rdata",        64'(d_rdata), 64'hCAFEF00D);

        // Contention with both requests held
        memLat = 1; memVal = 32'h0BADC0DE;
        grantStr = "";
        i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        for (int k = 0; k < 60 && grantStr.len() < 10; k++) @(negedge clock);
        i_req = 1'b0; d_req = 1'b0;
        nChecks++;
        if (grantStr != "DDDDIDDDDI") begin
            nFails++;
            $display("FAIL contention_order: got %s, expected DDDDIDDDDI", grantStr);
        end
        for (int k = 0; k < 10 && busy; k++) @(negedge clock);
        check("contention_drained", 64'(busy), 64'h0);
        check("model_starve_pin",   64'(mStarve), 64'd0);
        check("model_d_rdata_pin",  64'(mD), 64'h0BADC0DE);

        // Stray mem_ready while idle
        memMode = 0; manReady = 1'b1; manRdata = 32'h12345678;
        repeat (3) @(negedge clock);
        check("stray_i_rdata", 64'(i_rdata), 64'h0BADC0DE);
        check("stray_d_rdata", 64'(d_rdata), 64'h0BADC0DE);
        check("stray_busy",    64'(busy),    64'h0);
        manReady = 1'b0;

        // Reset in the middle of a fetch
        memMode = 1; memLat = 20; memVal = 32'h55AA55AA;
        @(negedge clock); i_req = 1'b1; i_addr = 32'h80;
        @(negedge clock);
        check("rstmid_mem_req", 64'(mem_req), 64'h1);
        i_req = 1'b0;
        #2 start = 1'b0;
        #1;
        check("rstmid_busy",     64'(busy),     64'h0);
        check("rstmid_mem_req0", 64'(mem_req),  64'h0);
        check("rstmid_mem_addr", 64'(mem_addr), 64'h0);
        check("rstmid_i_rdata",  64'(i_rdata),  64'h0);
        check("rstmid_d_rdata",  64'(d_rdata),  64'h0);
        @(negedge clock);
        @(negedge clock); start = 1'b1;
        cnt1 = 0; cnt2 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (i_ready) cnt1++;
            if (busy) cnt2++;
        end
        check("rstmid_no_i_ready", 64'(cnt1), 64'd0);
        check("rstmid_stay_idle",  64'(cnt2), 64'd0);
        memLat = 1; memVal = 32'h11112222;
        i_req = 1'b1; i_addr = 32'h84;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clock);
            i_req = 1'b0;
            if (i_ready) seen = 1'b1;
        end
        check("rstmid_served",  64'(seen),    64'h1);
        check("rstmid_i_rdata", 64'(i_rdata), 64'h11112222);

        // Random traffic with occasional asynchronous resets
        memMode = 2;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (!start) start = 1'b1;
            i_req   = 1'($urandom_range(0, 1));
            d_req   = ($urandom_range(0, 3) != 0);
            d_we    = 1'($urandom_range(0, 1));
            i_addr  = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                #3 start = 1'b0;
            end
        end
        @(negedge clock);
        start = 1'b1;
        repeat (2) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
